// File: rtl/serial_deserializer_if.sv
// ---------------------------------------------------------------------------
// serial_deserializer_if
//   Groups the serial input, control and parallel output signals of
//   serial_deserializer. clk and rst are plain ports on the module itself.
//
//   master modport (producer/consumer side, e.g. the testbench):
//     drives   en, start, in, direction, ack, clr_ovr
//     observes parallel_out, valid, busy, overrun
//   slave modport (the deserializer): the mirror image.
// ---------------------------------------------------------------------------
interface serial_deserializer_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             start;
    logic             in;
    logic             direction;
    logic             ack;
    logic             clr_ovr;
    logic [WIDTH-1:0] parallel_out;
    logic             valid;
    logic             busy;
    logic             overrun;

    modport master (
        output en, start, in, direction, ack, clr_ovr,
        input  parallel_out, valid, busy, overrun
    );

    modport slave (
        input  en, start, in, direction, ack, clr_ovr,
        output parallel_out, valid, busy, overrun
    );
endinterface

// File: rtl/serial_deserializer.sv
// ---------------------------------------------------------------------------
// serial_deserializer
//   Collects WIDTH serial bits, one per clock edge with en=1, into a parallel
//   word. A frame begins with start=1 (which also carries bit 1 and latches
//   the bit order); the edge sampling bit WIDTH publishes the word on
//   parallel_out with valid=1. Completing a word while the previous one is
//   still unacknowledged overwrites it and raises the sticky overrun flag.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   bus.en         bit-sample enable (stalls the frame when low)
//   bus.start      frame start, qualified by en; aborts a frame in progress
//   bus.in         serial data
//   bus.direction  0: first bit ends at MSB; 1: first bit ends at LSB
//   bus.ack        consumer acknowledge of parallel_out
//   bus.clr_ovr    clears overrun
//   bus.parallel_out  last completed word
//   bus.valid      parallel_out holds an unacknowledged word
//   bus.busy       a frame is being shifted in
//   bus.overrun    sticky: an unacknowledged word was overwritten
// ---------------------------------------------------------------------------
module serial_deserializer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_deserializer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_bit;
    logic             complete;
    logic             ovr_set;

    // Shift register with the current bit appended in the latched order.
    // MSB-first frames enter at bit 0 and move up; LSB-first frames enter at
    // the top and move down, so the first bit ends at bit 0.
    assign shifted   = dir_q ? {bus.in, shreg_q[WIDTH-1:1]}
                             : {shreg_q[WIDTH-2:0], bus.in};
    // A fresh frame uses the direction being latched on this same edge.
    assign first_bit = bus.direction ? {bus.in, {(WIDTH-1){1'b0}}}
                                     : {{(WIDTH-1){1'b0}}, bus.in};

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned; otherwise a latch would be inferred.
        state_d  = state_q;
        count_d  = count_q;
        shreg_d  = shreg_q;
        dir_d    = dir_q;
        complete = 1'b0;

        if (bus.en) begin
            if (bus.start) begin
                // Start is honoured in either state: in SHIFT it aborts the
                // partial frame, which is simply discarded.
                state_d = ST_SHIFT;
                count_d = CNT_ONE;
                dir_d   = bus.direction;
                shreg_d = first_bit;
            end else if (state_q == ST_SHIFT) begin
                shreg_d = shifted;
                count_d = count_q + CNT_ONE;
                if (count_q == CNT_LAST) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
        end
    end

    // A completion only counts as an overrun when the old word is still
    // pending and is not being acknowledged on this very edge.
    assign ovr_set = complete & valid_q & ~bus.ack;

    always_comb begin
        pout_d  = pout_q;
        valid_d = valid_q;
        if (complete) begin
            pout_d  = shifted;
            valid_d = 1'b1;
        end else if (valid_q && bus.ack) begin
            valid_d = 1'b0;
        end
        // Setting has priority over clearing.
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (bus.clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            shreg_q <= '0;
            dir_q   <= 1'b0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shreg_q <= shreg_d;
            dir_q   <= dir_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.parallel_out = pout_q;
    assign bus.valid        = valid_q;
    assign bus.busy         = (state_q == ST_SHIFT);
    assign bus.overrun      = ovr_q;
endmodule

// File: tb/tb_serial_deserializer.sv
// ---------------------------------------------------------------------------
// tb_serial_deserializer
//   Drives serial_deserializer through directed scenarios and a randomized
//   run. Expected outputs come from a frame-level model: received bits are
//   queued, and a finished frame is packed into a word arithmetically from
//   the bit positions implied by the latched direction.
// ---------------------------------------------------------------------------
module tb_serial_deserializer;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_deserializer_if #(.WIDTH(W)) bus ();

    serial_deserializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit           m_bits[$];
    logic         m_dir    = 1'b0;
    logic         m_active = 1'b0;
    logic [W-1:0] m_word   = '0;
    logic         m_valid  = 1'b0;
    logic         m_ovr    = 1'b0;

    function automatic void model_reset();
        m_bits.delete();
        m_dir    = 1'b0;
        m_active = 1'b0;
        m_word   = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
    endfunction

    // Frame bit k (0-based arrival order) lands at W-1-k for MSB-first, k for LSB-first.
    function automatic logic [W-1:0] model_pack();
        logic [W-1:0] w = '0;
        foreach (m_bits[k]) begin
            if (m_bits[k]) begin
                if (m_dir) w[k] = 1'b1;
                else       w[W-1-k] = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic void model_edge(logic en, logic st, logic din, logic dir,
                                       logic ak, logic cl);
        bit comp = 1'b0;
        if (en) begin
            if (st) begin
                m_bits.delete();
                m_bits.push_back(din);
                m_dir    = dir;
                m_active = 1'b1;
            end else if (m_active) begin
                m_bits.push_back(din);
                if (m_bits.size() == W) begin
                    comp     = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
        if (comp) begin
            if (m_valid && !ak) m_ovr = 1'b1;
            else if (cl)        m_ovr = 1'b0;
            m_word  = model_pack();
            m_valid = 1'b1;
        end else begin
            if (m_valid && ak) m_valid = 1'b0;
            if (cl)            m_ovr = 1'b0;
        end
    endfunction

    // One clock edge: drive inputs, advance the model, sample 1 time unit later.
    task automatic cycle(input logic en, input logic st, input logic din,
                         input logic dir, input logic ak, input logic cl);
        bus.en        = en;
        bus.start     = st;
        bus.in        = din;
        bus.direction = dir;
        bus.ack       = ak;
        bus.clr_ovr   = cl;
        model_edge(en, st, din, dir, ak, cl);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle(input logic ak, input logic cl);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, ak, cl);
    endtask

    // Sends one frame; stream bit W-1 is transmitted first. Optional 3-cycle
    // en=0 stall after the 4th bit, optional direction toggling mid-frame.
    task automatic send_frame(input logic [W-1:0] stream, input logic dir,
                              input bit gap, input bit flip,
                              input logic ak_last, input logic cl_last);
        for (int i = 0; i < W; i++) begin
            if (gap && i == 4) begin
                for (int g = 0; g < 3; g++)
                    cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          dir, 1'b0, 1'b0);
            end
            cycle(1'b1, (i == 0), stream[W-1-i], (flip && i > 0) ? ~dir : dir,
                  (i == W-1) ? ak_last : 1'b0, (i == W-1) ? cl_last : 1'b0);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.en    = 1'b1;
            bus.start = 1'($urandom_range(0, 1));
            bus.in    = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n_cmp++;
            if ({bus.parallel_out, bus.valid, bus.busy, bus.overrun} !== {8'h00, 3'b000}) begin
                n_bad++;
                $display("FAIL reset[%0d]: got out=%h v=%b b=%b o=%b, want all zero",
                         i, bus.parallel_out, bus.valid, bus.busy, bus.overrun);
            end
        end
        model_reset();
        bus.en = 1'b0;
        bus.start = 1'b0;
        rst = 1'b0;
        idle_cycle(1'b0, 1'b0);
    endtask

    task automatic test_msb_first();
        logic [W-1:0] stream = 8'hB2;
        for (int i = 0; i < W; i++) begin
            cycle(1'b1, (i == 0), stream[W-1-i], 1'b0, 1'b0, 1'b0);
            if (i == W-2) begin
                n_cmp++;
                if (bus.valid !== 1'b0 || bus.busy !== 1'b1) begin
                    n_bad++;
                    $display("FAIL msb_before_last: got v=%b b=%b, want v=0 b=1",
                             bus.valid, bus.busy);
                end
            end
        end
        n_cmp++;
        if ({bus.parallel_out, bus.valid, bus.busy, bus.overrun} !== {8'hB2, 3'b100}) begin
            n_bad++;
            $display("FAIL msb_first: got out=%h v=%b b=%b o=%b, want out=b2 v=1 b=0 o=0",
                     bus.parallel_out, bus.valid, bus.busy, bus.overrun);
        end
    endtask

    task automatic test_lsb_first();
        idle_cycle(1'b1, 1'b0);
        idle_cycle(1'b1, 1'b0);  // ack while valid=0 is ignored
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.parallel_out !== 8'hB2) begin
            n_bad++;
            $display("FAIL ack_idle: got v=%b out=%h, want v=0 out=b2", bus.valid, bus.parallel_out);
        end
        send_frame(8'hB2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.parallel_out !== 8'h4D || bus.valid !== 1'b1 || bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL lsb_first: got out=%h v=%b o=%b, want out=4d v=1 o=0",
                     bus.parallel_out, bus.valid, bus.overrun);
        end
        idle_cycle(1'b1, 1'b0);
        n_cmp++;
        if (bus.parallel_out !== 8'h4D || bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL lsb_ack: got out=%h v=%b, want out=4d v=0", bus.parallel_out, bus.valid);
        end
    endtask

    task automatic test_stall_abort();
        send_frame(8'hB2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.parallel_out !== 8'hB2 || bus.valid !== 1'b1 || bus.parallel_out !== m_word) begin
            n_bad++;
            $display("FAIL stall: got out=%h v=%b, want out=b2 v=1 (model %h)",
                     bus.parallel_out, bus.valid, m_word);
        end
        idle_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, (i == 0), 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.parallel_out !== 8'hB2 || bus.busy !== 1'b1 || bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_partial: got out=%h b=%b v=%b, want out=b2 b=1 v=0",
                     bus.parallel_out, bus.busy, bus.valid);
        end
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.parallel_out, bus.valid, bus.busy, bus.overrun} !== {8'h5A, 3'b100}) begin
            n_bad++;
            $display("FAIL abort_new: got out=%h v=%b b=%b o=%b, want out=5a v=1 b=0 o=0",
                     bus.parallel_out, bus.valid, bus.busy, bus.overrun);
        end
    endtask

    task automatic test_dir_change();
        idle_cycle(1'b1, 1'b0);
        send_frame(8'hB2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.parallel_out !== 8'hB2 || bus.parallel_out !== m_word) begin
            n_bad++;
            $display("FAIL dir_change: got out=%h, want out=b2 (model %h)", bus.parallel_out, m_word);
        end
    endtask

    task automatic test_overrun();
        idle_cycle(1'b1, 1'b1);
        send_frame(8'hB2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.parallel_out !== 8'h0F || bus.valid !== 1'b1 || bus.overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got out=%h v=%b o=%b, want out=0f v=1 o=1",
                     bus.parallel_out, bus.valid, bus.overrun);
        end
        idle_cycle(1'b0, 1'b1);
        n_cmp++;
        if (bus.overrun !== 1'b0 || bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_clr: got o=%b v=%b, want o=0 v=1", bus.overrun, bus.valid);
        end
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (bus.parallel_out !== 8'h55 || bus.valid !== 1'b1 || bus.overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_on_completion: got out=%h v=%b o=%b, want out=55 v=1 o=0",
                     bus.parallel_out, bus.valid, bus.overrun);
        end
        send_frame(8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.parallel_out !== 8'hAA || bus.overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_priority: got out=%h o=%b, want out=aa o=1",
                     bus.parallel_out, bus.overrun);
        end
    endtask

    task automatic test_midframe_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, (i == 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        n_cmp++;
        if ({bus.parallel_out, bus.valid, bus.busy, bus.overrun} !== {8'h00, 3'b000}) begin
            n_bad++;
            $display("FAIL async_reset: got out=%h v=%b b=%b o=%b, want all zero",
                     bus.parallel_out, bus.valid, bus.busy, bus.overrun);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL no_start_after_reset: got b=%b v=%b, want b=0 v=0", bus.busy, bus.valid);
        end
        send_frame(8'h96, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.parallel_out, bus.valid, bus.busy, bus.overrun} !== {8'h69, 3'b100}) begin
            n_bad++;
            $display("FAIL post_reset_frame: got out=%h v=%b b=%b o=%b, want out=69 v=1 b=0 o=0",
                     bus.parallel_out, bus.valid, bus.busy, bus.overrun);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 11) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
            n_cmp++;
            if ({bus.parallel_out, bus.valid, bus.busy, bus.overrun} !==
                {m_word, m_valid, m_active, m_ovr}) begin
                n_bad++;
                $display("FAIL random[%0d]: got out=%h v=%b b=%b o=%b, want out=%h v=%b b=%b o=%b",
                         i, bus.parallel_out, bus.valid, bus.busy, bus.overrun,
                         m_word, m_valid, m_active, m_ovr);
            end
        end
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.start     = 1'b0;
        bus.in        = 1'b0;
        bus.direction = 1'b0;
        bus.ack       = 1'b0;
        bus.clr_ovr   = 1'b0;
        model_reset();
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_stall_abort();
        test_dir_change();
        test_overrun();
        test_midframe_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
